// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the 5-stage MIPS core.
// Captures the decoded ID fields and detects load-use hazards. On a hazard it
// stalls IF/ID and inserts a bubble into EX. It also honours a downstream
// freeze (ex_hold) and a branch/jump flush, and it keeps a saturating count of
// inserted load-use bubbles for the debug unit.
module id_ex_stage #(
  parameter int CTRL_W      = 10,
  parameter int MEMREAD_BIT = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       id_pc_plus4,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm_ext,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_pc_plus4,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Update action applied to the EX register on the next clock edge.
  typedef enum logic [1:0] {
    UPD_LOAD  = 2'd0,
    UPD_HOLD  = 2'd1,
    UPD_FLUSH = 2'd2,
    UPD_STALL = 2'd3
  } upd_e;

  upd_e              upd;
  logic              ex_is_load;
  logic              rs_dep;
  logic              rt_dep;
  logic              load_use;
  logic              cnt_full;

  logic              nxt_valid;
  logic [CTRL_W-1:0] nxt_ctrl;
  logic [31:0]       nxt_pc_plus4;
  logic [31:0]       nxt_rs_data;
  logic [31:0]       nxt_rt_data;
  logic [31:0]       nxt_imm;
  logic [4:0]        nxt_rs;
  logic [4:0]        nxt_rt;
  logic [4:0]        nxt_rd;
  logic [CNT_W-1:0]  nxt_cnt;

  // Load-use hazard: a valid load in EX whose destination (ex_rt, never $zero)
  // is a source of the valid instruction now in ID.
  always_comb begin
    ex_is_load = ex_valid & ex_ctrl[MEMREAD_BIT];
    rs_dep     = (ex_rt == id_rs);
    rt_dep     = id_uses_rt & (ex_rt == id_rt);
    load_use   = ex_is_load & id_valid & (ex_rt != 5'd0) & (rs_dep | rt_dep);
  end

  // Pick the update action: freeze beats flush, flush beats load-use bubble.
  always_comb begin
    upd = UPD_LOAD;
    if (ex_hold) begin
      upd = UPD_HOLD;
    end else if (flush) begin
      upd = UPD_FLUSH;
    end else if (load_use) begin
      upd = UPD_STALL;
    end
  end

  // The stall is exactly the case where a load-use bubble is being inserted.
  assign hazard_stall = (upd == UPD_STALL);

  assign cnt_full = &bubble_cnt;

  // Next-state values for the EX register: keep, zero to a bubble, or capture ID.
  always_comb begin
    nxt_valid    = ex_valid;
    nxt_ctrl     = ex_ctrl;
    nxt_pc_plus4 = ex_pc_plus4;
    nxt_rs_data  = ex_rs_data;
    nxt_rt_data  = ex_rt_data;
    nxt_imm      = ex_imm;
    nxt_rs       = ex_rs;
    nxt_rt       = ex_rt;
    nxt_rd       = ex_rd;
    unique case (upd)
      UPD_HOLD: begin
        nxt_valid = ex_valid;
      end
      UPD_FLUSH, UPD_STALL: begin
        nxt_valid    = 1'b0;
        nxt_ctrl     = '0;
        nxt_pc_plus4 = '0;
        nxt_rs_data  = '0;
        nxt_rt_data  = '0;
        nxt_imm      = '0;
        nxt_rs       = '0;
        nxt_rt       = '0;
        nxt_rd       = '0;
      end
      default: begin
        nxt_valid    = id_valid;
        nxt_ctrl     = id_ctrl;
        nxt_pc_plus4 = id_pc_plus4;
        nxt_rs_data  = id_rs_data;
        nxt_rt_data  = id_rt_data;
        nxt_imm      = id_imm_ext;
        nxt_rs       = id_rs;
        nxt_rt       = id_rt;
        nxt_rd       = id_rd;
      end
    endcase
  end

  // Next bubble count: only load-use bubbles count, and the count sticks at all-ones.
  always_comb begin
    nxt_cnt = bubble_cnt;
    if ((upd == UPD_STALL) && !cnt_full) begin
      nxt_cnt = bubble_cnt + 1'b1;
    end
  end

  // Valid bit and control bundle; reset leaves EX holding a harmless bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else begin
      ex_valid <= nxt_valid;
      ex_ctrl  <= nxt_ctrl;
    end
  end

  // Data fields and register specifiers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc_plus4 <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
    end else begin
      ex_pc_plus4 <= nxt_pc_plus4;
      ex_rs_data  <= nxt_rs_data;
      ex_rt_data  <= nxt_rt_data;
      ex_imm      <= nxt_imm;
      ex_rs       <= nxt_rs;
      ex_rt       <= nxt_rt;
      ex_rd       <= nxt_rd;
    end
  end

  // Debug counter of inserted load-use bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else begin
      bubble_cnt <= nxt_cnt;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed, table-driven bench for the ID/EX pipeline register.
// A second instance with a 4-bit bubble counter exercises saturation quickly.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_ctrl;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm_ext;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_uses_rt;
  logic        ex_hold;
  logic        flush;

  logic        hazard_stall;
  logic        ex_valid;
  logic [9:0]  ex_ctrl;
  logic [31:0] ex_pc_plus4;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [15:0] bubble_cnt;

  logic        sat_hazard_stall;
  logic        sat_ex_valid;
  logic [9:0]  sat_ex_ctrl;
  logic [31:0] sat_ex_pc_plus4;
  logic [31:0] sat_ex_rs_data;
  logic [31:0] sat_ex_rt_data;
  logic [31:0] sat_ex_imm;
  logic [4:0]  sat_ex_rs;
  logic [4:0]  sat_ex_rt;
  logic [4:0]  sat_ex_rd;
  logic [3:0]  sat_bubble_cnt;

  int total_checks;
  int bad_checks;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm_ext(id_imm_ext), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .ex_hold(ex_hold), .flush(flush),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(4)) sat_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm_ext(id_imm_ext), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .ex_hold(ex_hold), .flush(flush),
    .hazard_stall(sat_hazard_stall), .ex_valid(sat_ex_valid), .ex_ctrl(sat_ex_ctrl),
    .ex_pc_plus4(sat_ex_pc_plus4), .ex_rs_data(sat_ex_rs_data), .ex_rt_data(sat_ex_rt_data),
    .ex_imm(sat_ex_imm), .ex_rs(sat_ex_rs), .ex_rt(sat_ex_rt), .ex_rd(sat_ex_rd),
    .bubble_cnt(sat_bubble_cnt)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        valid;
    logic [9:0]  ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        uses_rt;
    logic [31:0] rsd;
    logic [31:0] imm;
    logic        hold;
    logic        flsh;
    logic        e_stall;
    logic        e_valid;
    logic [9:0]  e_ctrl;
    logic [31:0] e_rsd;
    logic [31:0] e_imm;
    logic [4:0]  e_rt;
    logic [4:0]  e_rd;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(
    input logic v, input logic [9:0] c, input logic [4:0] s, input logic [4:0] t,
    input logic [4:0] d, input logic u, input logic [31:0] sd, input logic [31:0] im,
    input logic h, input logic f, input logic es, input logic ev, input logic [9:0] ec,
    input logic [31:0] esd, input logic [31:0] eim, input logic [4:0] et,
    input logic [4:0] ed, input logic [15:0] ecnt);
    vec_t r;
    r.valid = v;  r.ctrl = c;  r.rs = s;  r.rt = t;  r.rd = d;  r.uses_rt = u;
    r.rsd = sd;  r.imm = im;  r.hold = h;  r.flsh = f;
    r.e_stall = es;  r.e_valid = ev;  r.e_ctrl = ec;  r.e_rsd = esd;  r.e_imm = eim;
    r.e_rt = et;  r.e_rd = ed;  r.e_cnt = ecnt;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input logic [31:0] pc);
    id_valid    = v.valid;
    id_ctrl     = v.ctrl;
    id_rs       = v.rs;
    id_rt       = v.rt;
    id_rd       = v.rd;
    id_uses_rt  = v.uses_rt;
    id_rs_data  = v.rsd;
    id_rt_data  = v.rsd ^ 32'h0F0F_0F0F;
    id_imm_ext  = v.imm;
    id_pc_plus4 = pc;
    ex_hold     = v.hold;
    flush       = v.flsh;
  endtask

  // One cycle: drive, check the stall before the edge, then check the registers.
  task automatic runVec(input string tag, input vec_t v, input logic [31:0] pc);
    applyStimulus(v, pc);
    #1;
    checkOutput({tag, ".stall"}, {31'd0, hazard_stall}, {31'd0, v.e_stall});
    @(posedge clk);
    #1;
    checkOutput({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, v.e_valid});
    checkOutput({tag, ".ctrl"}, {22'd0, ex_ctrl}, {22'd0, v.e_ctrl});
    checkOutput({tag, ".rs_data"}, ex_rs_data, v.e_rsd);
    checkOutput({tag, ".imm"}, ex_imm, v.e_imm);
    checkOutput({tag, ".rt"}, {27'd0, ex_rt}, {27'd0, v.e_rt});
    checkOutput({tag, ".rd"}, {27'd0, ex_rd}, {27'd0, v.e_rd});
    checkOutput({tag, ".cnt"}, {16'd0, bubble_cnt}, {16'd0, v.e_cnt});
  endtask

  initial begin
    vec_t v;
    int   exp_main;
    int   exp_sat;
    total_checks = 0;
    bad_checks   = 0;

    // pass-through, load-use on rs, retry, no-stall cases (uses_rt=0, ex_rt=0)
    vecs[0]  = mk(1, 10'h081, 1, 2, 5, 1, 32'h12345678, 32'hFFFF8000, 0, 0,  0, 1, 10'h081, 32'h12345678, 32'hFFFF8000, 2, 5, 0);
    vecs[1]  = mk(1, 10'h00C, 3, 8, 0, 0, 32'h00001000, 32'h00000010, 0, 0,  0, 1, 10'h00C, 32'h00001000, 32'h00000010, 8, 0, 0);
    vecs[2]  = mk(1, 10'h081, 8, 9, 10, 1, 32'hAAAA0001, 32'h0, 0, 0,        1, 0, 10'h000, 32'h0, 32'h0, 0, 0, 1);
    vecs[3]  = mk(1, 10'h081, 8, 9, 10, 1, 32'hAAAA0001, 32'h0, 0, 0,        0, 1, 10'h081, 32'hAAAA0001, 32'h0, 9, 10, 1);
    vecs[4]  = mk(1, 10'h004, 4, 8, 0, 0, 32'h00002000, 32'h20, 0, 0,        0, 1, 10'h004, 32'h00002000, 32'h20, 8, 0, 1);
    vecs[5]  = mk(1, 10'h041, 7, 8, 0, 0, 32'h00003333, 32'h5, 0, 0,         0, 1, 10'h041, 32'h00003333, 32'h5, 8, 0, 1);
    vecs[6]  = mk(1, 10'h004, 1, 0, 0, 0, 32'h00004000, 32'h30, 0, 0,        0, 1, 10'h004, 32'h00004000, 32'h30, 0, 0, 1);
    vecs[7]  = mk(1, 10'h081, 0, 0, 3, 1, 32'h00005555, 32'h0, 0, 0,         0, 1, 10'h081, 32'h00005555, 32'h0, 0, 3, 1);
    // load-use through rt, flush beating load-use, invalid ID with matching specifiers
    vecs[8]  = mk(1, 10'h004, 2, 8, 0, 0, 32'h00006000, 32'h40, 0, 0,        0, 1, 10'h004, 32'h00006000, 32'h40, 8, 0, 1);
    vecs[9]  = mk(1, 10'h081, 1, 8, 11, 1, 32'h00007777, 32'h0, 0, 0,        1, 0, 10'h000, 32'h0, 32'h0, 0, 0, 2);
    vecs[10] = mk(1, 10'h081, 1, 8, 11, 1, 32'h00007777, 32'h0, 0, 0,        0, 1, 10'h081, 32'h00007777, 32'h0, 8, 11, 2);
    vecs[11] = mk(1, 10'h004, 2, 8, 0, 0, 32'h00006000, 32'h40, 0, 0,        0, 1, 10'h004, 32'h00006000, 32'h40, 8, 0, 2);
    vecs[12] = mk(1, 10'h081, 8, 9, 12, 1, 32'h00008888, 32'h0, 0, 1,        0, 0, 10'h000, 32'h0, 32'h0, 0, 0, 2);
    vecs[13] = mk(1, 10'h004, 2, 8, 0, 0, 32'h00006000, 32'h40, 0, 0,        0, 1, 10'h004, 32'h00006000, 32'h40, 8, 0, 2);
    vecs[14] = mk(0, 10'h081, 8, 9, 13, 1, 32'h00009999, 32'h1, 0, 0,        0, 0, 10'h081, 32'h00009999, 32'h1, 9, 13, 2);
    // back-to-back dependent loads, then hold with flush pending
    vecs[15] = mk(1, 10'h004, 1, 8, 0, 0, 32'h0000A000, 32'h4, 0, 0,         0, 1, 10'h004, 32'h0000A000, 32'h4, 8, 0, 2);
    vecs[16] = mk(1, 10'h004, 8, 9, 0, 0, 32'h0000B000, 32'h8, 0, 0,         1, 0, 10'h000, 32'h0, 32'h0, 0, 0, 3);
    vecs[17] = mk(1, 10'h004, 8, 9, 0, 0, 32'h0000B000, 32'h8, 0, 0,         0, 1, 10'h004, 32'h0000B000, 32'h8, 9, 0, 3);
    vecs[18] = mk(1, 10'h081, 9, 1, 2, 1, 32'h0000C000, 32'h9, 1, 1,         0, 1, 10'h004, 32'h0000B000, 32'h8, 9, 0, 3);
    vecs[19] = mk(1, 10'h081, 9, 1, 2, 1, 32'h0000D000, 32'h9, 1, 1,         0, 1, 10'h004, 32'h0000B000, 32'h8, 9, 0, 3);
    vecs[20] = mk(1, 10'h081, 9, 1, 2, 1, 32'h0000E000, 32'h9, 1, 1,         0, 1, 10'h004, 32'h0000B000, 32'h8, 9, 0, 3);
    vecs[21] = mk(1, 10'h081, 9, 1, 2, 1, 32'h0000E000, 32'h9, 0, 1,         0, 0, 10'h000, 32'h0, 32'h0, 0, 0, 3);
    // all-ones capture, then hold masking a load-use, then the stall once released
    vecs[22] = mk(1, 10'h3FF, 31, 31, 31, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1, 10'h3FF, 32'hFFFFFFFF, 32'hFFFFFFFF, 31, 31, 3);
    vecs[23] = mk(1, 10'h081, 31, 2, 6, 1, 32'h00001111, 32'h0, 1, 0,        0, 1, 10'h3FF, 32'hFFFFFFFF, 32'hFFFFFFFF, 31, 31, 3);
    vecs[24] = mk(1, 10'h081, 31, 2, 6, 1, 32'h00001111, 32'h0, 0, 0,        1, 0, 10'h000, 32'h0, 32'h0, 0, 0, 4);

    // Reset with random ID inputs: everything reads zero without any clock edge.
    rst_n       = 1'b0;
    id_valid    = 1'b1;
    id_ctrl     = 10'($urandom);
    id_pc_plus4 = $urandom;
    id_rs_data  = $urandom;
    id_rt_data  = $urandom;
    id_imm_ext  = $urandom;
    id_rs       = 5'($urandom);
    id_rt       = 5'($urandom);
    id_rd       = 5'($urandom);
    id_uses_rt  = 1'b1;
    ex_hold     = 1'b0;
    flush       = 1'b0;
    #2;
    checkOutput("reset.valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("reset.ctrl", {22'd0, ex_ctrl}, 32'd0);
    checkOutput("reset.rs_data", ex_rs_data, 32'd0);
    checkOutput("reset.imm", ex_imm, 32'd0);
    checkOutput("reset.cnt", {16'd0, bubble_cnt}, 32'd0);
    checkOutput("reset.stall", {31'd0, hazard_stall}, 32'd0);
    id_valid = 1'b0;
    id_ctrl = '0; id_pc_plus4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm_ext = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_uses_rt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      runVec($sformatf("vec%0d", i), vecs[i], 32'h0040_0000 + 32'(i * 4));
      checkOutput($sformatf("vec%0d.sat_cnt", i), {28'd0, sat_bubble_cnt}, {28'd0, vecs[i].e_cnt[3:0]});
    end

    // Saturation: the 4-bit instance sticks at 15 while the 16-bit one keeps counting.
    exp_main = 4;
    for (int k = 1; k <= 14; k++) begin
      v = mk(1, 10'h004, 1, 8, 0, 0, 32'h0000F000, 32'h0, 0, 0, 0, 1, 10'h004, 32'h0000F000, 32'h0, 8, 0, 16'(exp_main));
      runVec($sformatf("sat%0d.lw", k), v, 32'h0040_1000);
      exp_main = exp_main + 1;
      exp_sat  = (exp_main > 15) ? 15 : exp_main;
      v = mk(1, 10'h081, 8, 3, 4, 1, 32'h0000F004, 32'h0, 0, 0, 1, 0, 10'h000, 32'h0, 32'h0, 0, 0, 16'(exp_main));
      runVec($sformatf("sat%0d.use", k), v, 32'h0040_1004);
      checkOutput($sformatf("sat%0d.sat_cnt", k), {28'd0, sat_bubble_cnt}, 32'(exp_sat));
    end

    // Full pass-through including the fields the table does not check.
    id_valid = 1'b1; id_ctrl = 10'h081; id_pc_plus4 = 32'h0040_0100;
    id_rs = 5'd3; id_rt = 5'd4; id_rd = 5'd5; id_uses_rt = 1'b1;
    id_rs_data = 32'h1234_5678; id_rt_data = 32'h9ABC_DEF0; id_imm_ext = 32'hFFFF_8000;
    ex_hold = 1'b0; flush = 1'b0;
    #1;
    checkOutput("pass.stall", {31'd0, hazard_stall}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("pass.valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("pass.ctrl", {22'd0, ex_ctrl}, 32'h081);
    checkOutput("pass.pc", ex_pc_plus4, 32'h0040_0100);
    checkOutput("pass.rs_data", ex_rs_data, 32'h1234_5678);
    checkOutput("pass.rt_data", ex_rt_data, 32'h9ABC_DEF0);
    checkOutput("pass.imm", ex_imm, 32'hFFFF_8000);
    checkOutput("pass.rs", {27'd0, ex_rs}, 32'd3);
    checkOutput("pass.rt", {27'd0, ex_rt}, 32'd4);
    checkOutput("pass.rd", {27'd0, ex_rd}, 32'd5);

    // Mid-cycle asynchronous reset discards EX contents and both counters.
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("midrst.ctrl", {22'd0, ex_ctrl}, 32'd0);
    checkOutput("midrst.pc", ex_pc_plus4, 32'd0);
    checkOutput("midrst.rt_data", ex_rt_data, 32'd0);
    checkOutput("midrst.rs", {27'd0, ex_rs}, 32'd0);
    checkOutput("midrst.cnt", {16'd0, bubble_cnt}, 32'd0);
    checkOutput("midrst.sat_cnt", {28'd0, sat_bubble_cnt}, 32'd0);
    checkOutput("midrst.stall", {31'd0, hazard_stall}, 32'd0);
    id_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postrst.valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("postrst.cnt", {16'd0, bubble_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
